// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - 4-byte 8N1 UART frame transmitter with shadow register
// Sends DataTX_1..DataTX_4 LSB first, back to back, on each rising edge of EnTxData.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] DataTX_1,
  input  logic [7:0] DataTX_2,
  input  logic [7:0] DataTX_3,
  input  logic [7:0] DataTX_4,
  input  logic       EnTxData,
  output logic       TXD,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       frame_drop
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [31:0]       shadow_q, shadow_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              trigger;
  logic              baud_wrap;

  assign trigger   = EnTxData & ~en_q;
  assign baud_wrap = (baud_cnt_q == BAUD_LAST);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      shadow_q   <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= EnTxData;
      shadow_q   <= shadow_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    txd_d      = 1'b1;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (trigger) begin
          shadow_d   = {DataTX_4, DataTX_3, DataTX_2, DataTX_1};
          byte_idx_d = '0;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_wrap) state_d = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (byte_idx_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A request edge while a frame is in flight is reported and discarded.
    if (trigger && state_q != IDLE) drop_d = 1'b1;

    // Outputs are computed from the next state so they are registered yet aligned.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shadow_d[{byte_idx_d, bit_idx_d}];
      default: txd_d = 1'b1;
    endcase
  end

  assign TXD        = txd_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign frame_drop = drop_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame at CLKS_PER_BIT=4
// Directed frames push expected bytes; a TXD-decoding monitor pops and compares.
module tb_uart_tx_frame;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic [7:0] DataTX_1, DataTX_2, DataTX_3, DataTX_4;
  logic       EnTxData;
  logic       TXD, tx_busy, tx_done, frame_drop;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         drop_cnt = 0;
  logic [7:0] exp_q[$];

  uart_tx_frame #(.CLKS_PER_BIT(4)) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .DataTX_1   (DataTX_1),
    .DataTX_2   (DataTX_2),
    .DataTX_3   (DataTX_3),
    .DataTX_4   (DataTX_4),
    .EnTxData   (EnTxData),
    .TXD        (TXD),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .frame_drop (frame_drop)
  );

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_byte(input logic [9:0] bits);
    logic [7:0] exp;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL rx_byte: unexpected byte 0x%0h, expected no frame", bits[8:1]);
    end else begin
      exp = exp_q.pop_front();
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== exp) begin
        miscompares++;
        $display("FAIL rx_byte: got start=%b data=0x%0h stop=%b, expected start=0 data=0x%0h stop=1",
                 bits[0], bits[8:1], bits[9], exp);
      end
    end
  endtask

  // TXD decoder: sample the middle of each 4-cycle bit, starting at the first low cycle.
  int         mon_cnt = 0;
  bit         mon_active = 1'b0;
  logic [9:0] mon_bits;
  logic       prev_txd = 1'b1;

  always @(negedge clk_50m) begin
    if (rst) begin
      mon_active = 1'b0;
      prev_txd   = 1'b1;
    end else begin
      if (tx_done)    done_cnt++;
      if (frame_drop) drop_cnt++;
      if (!mon_active && prev_txd && !TXD) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
      if (mon_active) begin
        if (mon_cnt % 4 == 2) mon_bits[mon_cnt / 4] = TXD;
        if (mon_cnt == 38) begin
          mon_active = 1'b0;
          check_byte(mon_bits);
        end
        mon_cnt++;
      end
      prev_txd = TXD;
    end
  end

  task automatic start_frame(input logic [7:0] b1, b2, b3, b4, input bit sent, output int k);
    @(posedge clk_50m); #1;
    DataTX_1 = b1; DataTX_2 = b2; DataTX_3 = b3; DataTX_4 = b4;
    EnTxData = 1'b1;
    if (sent) begin
      exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3); exp_q.push_back(b4);
    end
    @(posedge clk_50m); #1;
    k = cyc;
    EnTxData = 1'b0;
    DataTX_1 = 8'h00; DataTX_2 = 8'h00; DataTX_3 = 8'h00; DataTX_4 = 8'h00;
  endtask

  initial begin
    int k, d0, p0, first_busy, busy_n, done_at, done_txd, done_busy, n;
    rst = 1'b1; EnTxData = 1'b0;
    DataTX_1 = '0; DataTX_2 = '0; DataTX_3 = '0; DataTX_4 = '0;
    repeat (3) @(posedge clk_50m);
    #1;
    check("reset_txd", TXD, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_drop", frame_drop, 0);
    @(negedge clk_50m); rst = 1'b0;

    // Basic frame with exact timing of busy and done.
    d0 = done_cnt; p0 = drop_cnt;
    start_frame(8'h55, 8'hA3, 8'h00, 8'hFF, 1'b1, k);
    first_busy = -1; busy_n = 0; done_at = -1; done_txd = 0; done_busy = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_50m);
      if (tx_busy) begin
        busy_n++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (tx_done && done_at < 0) begin
        done_at = cyc; done_txd = TXD; done_busy = tx_busy;
      end
    end
    check("basic_busy_first", first_busy - k, 0);
    check("basic_busy_len", busy_n, 160);
    check("basic_done_at", done_at - k, 160);
    check("basic_done_txd", done_txd, 1);
    check("basic_done_busy", done_busy, 0);
    check("basic_done_cnt", done_cnt - d0, 1);
    check("basic_drop_cnt", drop_cnt - p0, 0);

    // Held request: one frame only, then a fresh edge sends another.
    d0 = done_cnt; p0 = drop_cnt;
    @(posedge clk_50m); #1;
    DataTX_1 = 8'h12; DataTX_2 = 8'h34; DataTX_3 = 8'h56; DataTX_4 = 8'h78;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    EnTxData = 1'b1;
    repeat (500) @(posedge clk_50m);
    #1; EnTxData = 1'b0;
    check("held_done_cnt", done_cnt - d0, 1);
    check("held_drop_cnt", drop_cnt - p0, 0);
    d0 = done_cnt;
    start_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, k);
    repeat (180) @(posedge clk_50m);
    check("held_refire_done", done_cnt - d0, 1);

    // Busy collision: second edge dropped, first frame intact.
    d0 = done_cnt; p0 = drop_cnt;
    start_frame(8'hC3, 8'h3C, 8'h81, 8'h7E, 1'b1, k);
    repeat (48) @(posedge clk_50m);
    start_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, n);
    repeat (400) @(posedge clk_50m);
    check("collide_drop_cnt", drop_cnt - p0, 1);
    check("collide_done_cnt", done_cnt - d0, 1);

    // Back-to-back: next edge sampled at the end of the tx_done cycle.
    d0 = done_cnt; p0 = drop_cnt;
    start_frame(8'h01, 8'h80, 8'hF0, 8'h0F, 1'b1, k);
    n = 0;
    do begin
      @(negedge clk_50m); n++;
    end while (!tx_done && n < 300);
    check("b2b_done_seen", tx_done, 1);
    done_at = cyc;
    DataTX_1 = 8'h9A; DataTX_2 = 8'hBC; DataTX_3 = 8'hDE; DataTX_4 = 8'h24;
    exp_q.push_back(8'h9A); exp_q.push_back(8'hBC); exp_q.push_back(8'hDE); exp_q.push_back(8'h24);
    EnTxData = 1'b1;
    @(posedge clk_50m); #1;
    EnTxData = 1'b0;
    DataTX_1 = '0; DataTX_2 = '0; DataTX_3 = '0; DataTX_4 = '0;
    @(negedge clk_50m);
    check("b2b_start_cyc", cyc - done_at, 1);
    check("b2b_start_txd", TXD, 0);
    check("b2b_busy", tx_busy, 1);
    repeat (200) @(posedge clk_50m);
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_drop_cnt", drop_cnt - p0, 0);

    // Reset during byte 2, data bit 3 (bit value 0), then a full frame afterwards.
    d0 = done_cnt;
    start_frame(8'hA5, 8'h5A, 8'h00, 8'h3C, 1'b1, k);
    n = 0;
    do begin
      @(negedge clk_50m); n++;
    end while (cyc < k + 97 && n < 300);
    check("rst_pre_txd", TXD, 0);
    check("rst_pre_busy", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_txd", TXD, 1);
    check("rst_async_busy", tx_busy, 0);
    check("rst_async_done", tx_done, 0);
    exp_q.delete();
    repeat (3) @(posedge clk_50m);
    #3 rst = 1'b0;
    check("rst_no_done", done_cnt - d0, 0);
    start_frame(8'h6B, 8'hE2, 8'h17, 8'hC8, 1'b1, k);
    repeat (180) @(posedge clk_50m);
    check("rst_after_done", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
